// File: rtl/relu_arbiter_if.sv
// Requester-side bundle for the shared relu arbiter: per-requester beat
// handshake going in, one-hot tagged results coming back.
interface relu_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic signed [DATA_W-1:0]  rsp_data;

  modport master (
    output req_valid, req_last, req_data,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_last, req_data,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/relu_arbiter.sv
// Round-robin burst arbiter sharing one relu datapath among NUM_REQ
// requesters. Each issued beat carries its owner's id down a tag pipeline
// that tracks the relu latency, so results are steered back one-hot.
module relu_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int RELU_LAT  = 1,
  parameter int MAX_BURST = 16,
  parameter int STALL_MAX = 8,
  localparam int IDW      = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  relu_arbiter_if.slave            bus,
  output logic signed [DATA_W-1:0] relu_din,
  output logic                     relu_ivalid,
  input  logic signed [DATA_W-1:0] relu_dout,
  input  logic                     relu_ovalid,
  output logic [IDW-1:0]           grant_id,
  output logic                     busy,
  output logic                     err
);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int SW = $clog2(STALL_MAX + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                   state;
  logic [IDW-1:0]           rr_ptr;
  logic [BW-1:0]            beat_cnt;
  logic [SW-1:0]            stall_cnt;
  logic [IDW-1:0]           winner;
  logic                     any_req;
  logic signed [DATA_W-1:0] req_word [NUM_REQ];
  logic                     acc;
  logic                     rel;
  logic [IDW-1:0]           next_ptr;
  logic [IDW-1:0]           tag_p0;
  logic [RELU_LAT-1:0]      vld_p1;
  logic [IDW-1:0]           tag_p1 [RELU_LAT];
  logic [NUM_REQ-1:0]       rsp_valid_p2;
  logic signed [DATA_W-1:0] rsp_data_p2;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDW-1:0] id);
    logic [NUM_REQ-1:0] r;
    r     = '0;
    r[id] = 1'b1;
    return r;
  endfunction

  // Unpack the flat requester data bus into per-requester words.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_word[i] = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  // Winner: first valid requester at or after rr_ptr, searching upward with wrap.
  always_comb begin
    int idx;
    idx     = 0;
    winner  = '0;
    any_req = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_req && bus.req_valid[IDW'(idx)]) begin
        any_req = 1'b1;
        winner  = IDW'(idx);
      end
    end
  end

  assign busy          = (state == BURST);
  assign bus.req_ready = busy ? onehot(grant_id) : '0;
  assign acc           = busy && bus.req_valid[grant_id];
  assign next_ptr      = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
  // Release on a last beat, on the beat that fills the burst, or on the idle
  // cycle that would bring the stall count up to STALL_MAX.
  assign rel = acc ? (bus.req_last[grant_id] || (beat_cnt == BW'(MAX_BURST - 1)))
                   : (stall_cnt == SW'(STALL_MAX - 1));

  // Grant FSM: IDLE picks a winner, BURST counts beats and idle cycles until release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant_id  <= '0;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state    <= BURST;
            grant_id <= winner;
          end
        end
        BURST: begin
          if (rel) begin
            state     <= IDLE;
            rr_ptr    <= next_ptr;
            beat_cnt  <= '0;
            stall_cnt <= '0;
          end else if (acc) begin
            beat_cnt  <= beat_cnt + BW'(1);
            stall_cnt <= '0;
          end else begin
            stall_cnt <= stall_cnt + SW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p0: issue the accepted beat to the relu unit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      relu_ivalid <= 1'b0;
      relu_din    <= '0;
    end else begin
      relu_ivalid <= acc;
      if (acc) relu_din <= req_word[grant_id];
    end
  end

  // Stage p0: owner tag captured alongside the issued beat.
  always_ff @(posedge clk) begin
    if (acc) tag_p0 <= grant_id;
  end

  // Stage p1: tag-valid shift register, output stage lines up with relu_ovalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= '0;
    end else begin
      vld_p1[0] <= relu_ivalid;
      for (int i = 1; i < RELU_LAT; i++) vld_p1[i] <= vld_p1[i-1];
    end
  end

  // Stage p1: tag id shift register travelling with vld_p1.
  always_ff @(posedge clk) begin
    tag_p1[0] <= tag_p0;
    for (int i = 1; i < RELU_LAT; i++) tag_p1[i] <= tag_p1[i-1];
  end

  // Stage p2: steer the relu result to its owner; an untagged result is an error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_p2 <= '0;
      rsp_data_p2  <= '0;
      err          <= 1'b0;
    end else begin
      rsp_valid_p2 <= '0;
      if (relu_ovalid) begin
        if (vld_p1[RELU_LAT-1]) begin
          rsp_valid_p2 <= onehot(tag_p1[RELU_LAT-1]);
          rsp_data_p2  <= relu_dout;
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_p2;
  assign bus.rsp_data  = rsp_data_p2;
endmodule

// File: tb/tb_relu_arbiter.sv
// Directed bench for relu_arbiter: a behavioural one-cycle relu, table-driven
// requester sources, and logs of grants and responses checked against
// hand-computed sequences.
module tb_relu_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic signed [DATA_W-1:0] relu_din;
  logic                     relu_ivalid;
  logic signed [DATA_W-1:0] relu_dout;
  logic                     relu_ovalid;
  logic [1:0]               grant_id;
  logic                     busy;
  logic                     err;

  logic                     ov_q   = 1'b0;
  logic signed [DATA_W-1:0] dout_q = '0;
  logic                     inj_ov = 1'b0;

  int errors = 0;
  int checks = 0;

  // requester sources: value table, length, position, last mode (0 none, 1 at end, 2 every beat)
  int vals [NUM_REQ][24];
  int len  [NUM_REQ];
  int pos  [NUM_REQ];
  int mode [NUM_REQ];

  int         glog [$];
  logic [3:0] rtag [$];
  logic [31:0] rdat [$];
  logic       busy_d = 1'b0;

  relu_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bif ();

  relu_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .RELU_LAT(1), .MAX_BURST(16), .STALL_MAX(8)
  ) dut (
    .clk(clk), .rst(rst), .bus(bif.slave),
    .relu_din(relu_din), .relu_ivalid(relu_ivalid),
    .relu_dout(relu_dout), .relu_ovalid(relu_ovalid),
    .grant_id(grant_id), .busy(busy), .err(err)
  );

  initial forever #5 clk = ~clk;

  // behavioural relu, latency 1
  always @(posedge clk) begin
    ov_q   <= relu_ivalid;
    dout_q <= (relu_din < 0) ? '0 : relu_din;
  end
  assign relu_ovalid = ov_q | inj_ov;
  assign relu_dout   = dout_q;

  // mid-cycle logging of grant starts and responses
  always @(negedge clk) begin
    if (busy && !busy_d) glog.push_back(int'(grant_id));
    busy_d = busy;
    if (bif.rsp_valid != '0) begin
      rtag.push_back(bif.rsp_valid);
      rdat.push_back(bif.rsp_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    logic [NUM_REQ-1:0]        v;
    logic [NUM_REQ-1:0]        l;
    logic [NUM_REQ*DATA_W-1:0] d;
    v = '0; l = '0; d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      v[i] = (pos[i] < len[i]);
      l[i] = (mode[i] == 2) || (mode[i] == 1 && pos[i] == len[i] - 1);
      if (pos[i] < 24) d[i*DATA_W +: DATA_W] = vals[i][pos[i]];
    end
    bif.req_valid = v;
    bif.req_last  = l;
    bif.req_data  = d;
  endtask

  task automatic tick();
    logic [NUM_REQ-1:0] a;
    drive();
    a = bif.req_valid & bif.req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) if (a[i]) pos[i]++;
    drive();
  endtask

  task automatic clear_src();
    for (int i = 0; i < NUM_REQ; i++) begin
      len[i] = 0; pos[i] = 0; mode[i] = 0;
      for (int j = 0; j < 24; j++) vals[i][j] = 0;
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    inj_ov = 1'b0;
    clear_src();
    drive();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    glog.delete(); rtag.delete(); rdat.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- single requester, reset values ----
    reset_dut();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_ready", 32'(bif.req_ready), 0);
    chk("rst_ivalid", 32'(relu_ivalid), 0);
    chk("rst_din", relu_din, 0);
    chk("rst_rspv", 32'(bif.rsp_valid), 0);
    chk("rst_rspd", bif.rsp_data, 0);
    chk("rst_err", 32'(err), 0);
    vals[2][0] = -5; vals[2][1] = 7; vals[2][2] = 0; len[2] = 3; mode[2] = 1;
    tick();
    chk("t1_busy", 32'(busy), 1);
    chk("t1_grant", 32'(grant_id), 2);
    chk("t1_ready", 32'(bif.req_ready), 32'h4);
    chk("t1_ivalid0", 32'(relu_ivalid), 0);
    tick();
    chk("t1_ivalid1", 32'(relu_ivalid), 1);
    chk("t1_din1", relu_din, -5);
    tick();
    chk("t1_ivalid2", 32'(relu_ivalid), 1);
    chk("t1_din2", relu_din, 7);
    chk("t1_rspv_early", 32'(bif.rsp_valid), 0);
    tick();
    chk("t1_ivalid3", 32'(relu_ivalid), 1);
    chk("t1_busy_rel", 32'(busy), 0);
    chk("t1_ready_rel", 32'(bif.req_ready), 0);
    chk("t1_rspv_a", 32'(bif.rsp_valid), 32'h4);
    chk("t1_rspd_a", bif.rsp_data, 0);
    tick();
    chk("t1_ivalid4", 32'(relu_ivalid), 0);
    chk("t1_rspv_b", 32'(bif.rsp_valid), 32'h4);
    chk("t1_rspd_b", bif.rsp_data, 7);
    tick();
    chk("t1_rspv_c", 32'(bif.rsp_valid), 32'h4);
    chk("t1_rspd_c", bif.rsp_data, 0);
    tick();
    chk("t1_rspv_d", 32'(bif.rsp_valid), 0);
    chk("t1_rspd_hold", bif.rsp_data, 0);

    // ---- round robin with 1-beat bursts ----
    reset_dut();
    vals[0][0] = -100; vals[0][1] = 9; len[0] = 2; mode[0] = 2;
    vals[1][0] = 200;  len[1] = 1; mode[1] = 2;
    vals[2][0] = -3;   len[2] = 1; mode[2] = 2;
    vals[3][0] = 55;   len[3] = 1; mode[3] = 2;
    repeat (16) tick();
    chk("rr_ngrant", glog.size(), 5);
    chk("rr_g0", glog[0], 0);
    chk("rr_g1", glog[1], 1);
    chk("rr_g2", glog[2], 2);
    chk("rr_g3", glog[3], 3);
    chk("rr_g4", glog[4], 0);
    chk("rr_nrsp", rtag.size(), 5);
    chk("rr_t0", 32'(rtag[0]), 32'h1);
    chk("rr_d0", rdat[0], 0);
    chk("rr_t1", 32'(rtag[1]), 32'h2);
    chk("rr_d1", rdat[1], 200);
    chk("rr_t2", 32'(rtag[2]), 32'h4);
    chk("rr_d2", rdat[2], 0);
    chk("rr_t3", 32'(rtag[3]), 32'h8);
    chk("rr_d3", rdat[3], 55);
    chk("rr_t4", 32'(rtag[4]), 32'h1);
    chk("rr_d4", rdat[4], 9);

    // ---- MAX_BURST forced release ----
    reset_dut();
    for (int k = 0; k < 20; k++) vals[1][k] = k + 1;
    len[1] = 20; mode[1] = 0;
    vals[2][0] = 1000; len[2] = 1; mode[2] = 1;
    repeat (40) tick();
    chk("mb_ngrant", glog.size(), 3);
    chk("mb_g0", glog[0], 1);
    chk("mb_g1", glog[1], 2);
    chk("mb_g2", glog[2], 1);
    chk("mb_nrsp", rtag.size(), 21);
    chk("mb_d15", rdat[15], 16);
    chk("mb_t15", 32'(rtag[15]), 32'h2);
    chk("mb_d16", rdat[16], 1000);
    chk("mb_t16", 32'(rtag[16]), 32'h4);
    chk("mb_d17", rdat[17], 17);
    chk("mb_d20", rdat[20], 20);
    chk("mb_t20", 32'(rtag[20]), 32'h2);

    // ---- stall release ----
    reset_dut();
    vals[0][0] = 3;  len[0] = 1; mode[0] = 0;
    vals[3][0] = -9; len[3] = 1; mode[3] = 1;
    tick();
    chk("st_busy0", 32'(busy), 1);
    chk("st_grant0", 32'(grant_id), 0);
    tick();
    repeat (7) tick();
    chk("st_busy_held", 32'(busy), 1);
    tick();
    chk("st_busy_rel", 32'(busy), 0);
    chk("st_ready_rel", 32'(bif.req_ready), 0);
    tick();
    chk("st_busy3", 32'(busy), 1);
    chk("st_grant3", 32'(grant_id), 3);

    // ---- async reset mid-burst ----
    reset_dut();
    vals[1][0] = 11; vals[1][1] = 22; vals[1][2] = 33; vals[1][3] = 44;
    len[1] = 4; mode[1] = 1;
    tick(); tick(); tick();
    chk("ar_inflight", 32'(relu_ivalid), 1);
    rst = 1'b1;
    clear_src();
    drive();
    #1;
    chk("ar_busy", 32'(busy), 0);
    chk("ar_ready", 32'(bif.req_ready), 0);
    chk("ar_ivalid", 32'(relu_ivalid), 0);
    chk("ar_din", relu_din, 0);
    chk("ar_grant", 32'(grant_id), 0);
    chk("ar_rspv", 32'(bif.rsp_valid), 0);
    chk("ar_err0", 32'(err), 0);
    tick(); tick();
    rst = 1'b0;
    inj_ov = 1'b1;
    tick();
    inj_ov = 1'b0;
    chk("ar_err1", 32'(err), 1);
    chk("ar_rspv1", 32'(bif.rsp_valid), 0);
    tick();
    chk("ar_err_sticky", 32'(err), 1);
    chk("ar_nrsp", rtag.size(), 0);

    // ---- release coinciding with a new request ----
    reset_dut();
    vals[1][0] = 5; vals[1][1] = 6; len[1] = 2; mode[1] = 1;
    tick(); tick();
    vals[0][0] = 77; len[0] = 1; mode[0] = 1;
    tick();
    chk("sim_busy_rel", 32'(busy), 0);
    tick();
    chk("sim_busy", 32'(busy), 1);
    chk("sim_grant", 32'(grant_id), 0);
    chk("sim_ready", 32'(bif.req_ready), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
